// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between two requesters.
// Round-robin grant on valid/ready, operands registered and held on the ALU
// for ALU_LAT cycles, result and flags returned on one tagged response channel.
// Optional macro ALU_SHARE_ARB_PERF_EN adds saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int ALU_LAT = 2,
    parameter int WIDTH   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1
`endif
);

    localparam int CNT_W = 4;  // holds ALU_LAT-1 for the legal range 1..15

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             cur_id;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_any;
    logic             grant_id;

    // Round-robin pick among valid requesters; only IDLE may grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            grant_any = req0_valid | req1_valid;
            if (req0_valid && req1_valid) begin
                grant_id = ~last_grant;
            end else begin
                grant_id = ~req0_valid;
            end
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    // Arbitration FSM: capture operands, hold for the settle time, return the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cntrl  <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'b0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        alu_cntrl  <= grant_id ? req1_op : req0_op;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        wait_cnt   <= CNT_W'(ALU_LAT - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_ARB_PERF_EN
    // Saturating grant counters, one per requester, stepped on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready && (grant_cnt0 != 32'hFFFF_FFFF)) begin
                grant_cnt0 <= grant_cnt0 + 32'd1;
            end
            if (req1_valid && req1_ready && (grant_cnt1 != 32'hFFFF_FFFF)) begin
                grant_cnt1 <= grant_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a behavioural
// 64-bit ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

    localparam int WIDTH   = 64;
    localparam int ALU_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_cntrl;
    logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0]      grant_cnt0, grant_cnt1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.ALU_LAT(ALU_LAT), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef ALU_SHARE_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Behavioural ALU: 010 add, 011 subtract (carry = no borrow), 000 and, 001 or.
    always_comb begin
        logic [WIDTH:0] sum;
        sum          = '0;
        alu_overflow = 1'b0;
        case (alu_cntrl)
            3'b010: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b011: begin
                sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b000:  sum = {1'b0, alu_a & alu_b};
            3'b001:  sum = {1'b0, alu_a | alu_b};
            default: sum = '0;
        endcase
        alu_result    = sum[WIDTH-1:0];
        alu_carry_out = sum[WIDTH];
        alu_negative  = sum[WIDTH-1];
        alu_zero      = (sum[WIDTH-1:0] == '0);
    end

    // Present one op on a requester and wait (bounded) for its handshake.
    // Returns at posedge+1 of the accepting edge with valid dropped.
    task automatic accept(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] op, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Count edges from the accepting edge (edge 1) until rsp_valid; -1 on timeout.
    task automatic wait_rsp(output int edges);
        bit found;
        found = 1'b0;
        edges = 1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        if (!found) edges = -1;
    endtask

    // Accept the pending response with a single-cycle rsp_ready pulse.
    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        #12;
        n_cmp++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000", {req0_ready, req1_ready, rsp_valid, rsp_id});
        end
        n_cmp++;
        if ({rsp_result, rsp_flags} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: got %h/%b expected 0/0000", rsp_result, rsp_flags);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_cntrl} !== '0) begin
            n_err++;
            $display("FAIL reset_alu: got %h %h %b expected zeros", alu_a, alu_b, alu_cntrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int e;
        accept(1'b0, 64'd5, 64'd3, 3'b010, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_accept: got no handshake expected handshake"); end
        n_cmp++;
        if ({alu_a, alu_b, alu_cntrl} !== {64'd5, 64'd3, 3'b010}) begin
            n_err++;
            $display("FAIL single_alu_drive: got %h %h %b expected 5 3 010", alu_a, alu_b, alu_cntrl);
        end
        wait_rsp(e);
        n_cmp++;
        if (e !== ALU_LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", e, ALU_LAT + 1); end
        n_cmp++;
        if ({rsp_id, rsp_result, rsp_flags} !== {1'b0, 64'd8, 4'b0000}) begin
            n_err++;
            $display("FAIL single_rsp: got id=%0d res=%h fl=%b expected id=0 res=8 fl=0000", rsp_id, rsp_result, rsp_flags);
        end
        consume();
        n_cmp++;
        if ({rsp_valid, alu_a, alu_b} !== {1'b0, 64'd5, 64'd3}) begin
            n_err++;
            $display("FAIL single_hold_after: got v=%b a=%h b=%h expected v=0 a=5 b=3", rsp_valid, alu_a, alu_b);
        end
        // Undefined opcode must reach the ALU untouched.
        accept(1'b0, 64'h1234, 64'h1, 3'b110, ok);
        n_cmp++;
        if (!ok || alu_cntrl !== 3'b110) begin
            n_err++;
            $display("FAIL op_passthrough: got ok=%b cntrl=%b expected ok=1 cntrl=110", ok, alu_cntrl);
        end
        wait_rsp(e);
        consume();
    endtask

    task automatic test_sub();
        bit ok;
        int e;
        accept(1'b1, 64'd7, 64'd7, 3'b011, ok);
        wait_rsp(e);
        n_cmp++;
        if ({ok, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 64'd0, 4'b0101}) begin
            n_err++;
            $display("FAIL sub_zero: got ok=%b id=%0d res=%h fl=%b expected ok=1 id=1 res=0 fl=0101", ok, rsp_id, rsp_result, rsp_flags);
        end
        consume();
        accept(1'b1, 64'd0, 64'd1, 3'b011, ok);
        wait_rsp(e);
        n_cmp++;
        if ({ok, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}) begin
            n_err++;
            $display("FAIL sub_neg: got ok=%b id=%0d res=%h fl=%b expected ok=1 id=1 res=ffffffffffffffff fl=1000", ok, rsp_id, rsp_result, rsp_flags);
        end
        consume();
    endtask

    task automatic test_tie();
        bit             gid [4];
        int             gcyc [4];
        bit             rid [4];
        logic [WIDTH-1:0] rres [4];
        int             ng, nr;
        bit             both;
        ng = 0; nr = 0; both = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_a = 64'd1;  req0_b = 64'd2; req0_op = 3'b010; req0_valid = 1'b1;
        req1_a = 64'd10; req1_b = 64'd4; req1_op = 3'b011; req1_valid = 1'b1;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both = 1'b1;
            if ((req0_ready || req1_ready) && ng < 4) begin
                gid[ng] = req1_ready; gcyc[ng] = c; ng++;
            end
            if (rsp_valid && nr < 4) begin
                rid[nr] = rsp_id; rres[nr] = rsp_result; nr++;
            end
            @(posedge clk);
            #1;
            if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        n_cmp++;
        if (ng != 4 || nr != 4) begin n_err++; $display("FAIL tie_counts: got %0d grants %0d rsps expected 4 4", ng, nr); end
        else begin
            n_cmp++;
            if ({gid[3], gid[2], gid[1], gid[0]} !== 4'b1010) begin
                n_err++; $display("FAIL tie_grant_order: got %b expected 1010 (lsb first)", {gid[3], gid[2], gid[1], gid[0]});
            end
            n_cmp++;
            if ({rid[3], rid[2], rid[1], rid[0]} !== 4'b1010) begin
                n_err++; $display("FAIL tie_rsp_ids: got %b expected 1010 (lsb first)", {rid[3], rid[2], rid[1], rid[0]});
            end
            n_cmp++;
            if (rres[0] !== 64'd3 || rres[1] !== 64'd6 || rres[2] !== 64'd3 || rres[3] !== 64'd6) begin
                n_err++; $display("FAIL tie_results: got %0h %0h %0h %0h expected 3 6 3 6", rres[0], rres[1], rres[2], rres[3]);
            end
            n_cmp++;
            if (gcyc[1] - gcyc[0] != ALU_LAT + 2 || gcyc[3] - gcyc[2] != ALU_LAT + 2) begin
                n_err++; $display("FAIL tie_throughput: got spacing %0d/%0d expected %0d", gcyc[1] - gcyc[0], gcyc[3] - gcyc[2], ALU_LAT + 2);
            end
        end
        n_cmp++;
        if (both) begin n_err++; $display("FAIL tie_both_ready: got both ready high expected never"); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_res;
        logic [3:0]       held_fl;
        int               e, unstable, ready_hi;
        rsp_ready = 1'b0;
        unstable = 0; ready_hi = 0;
        @(negedge clk);
        req0_a = 64'h8000_0000_0000_0000; req0_b = 64'h8000_0000_0000_0000; req0_op = 3'b010; req0_valid = 1'b1;
        req1_a = 64'd3; req1_b = 64'd5; req1_op = 3'b011; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL bp_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_rsp(e);
        n_cmp++;
        if ({rsp_id, rsp_result, rsp_flags} !== {1'b0, 64'd0, 4'b0111}) begin
            n_err++; $display("FAIL bp_rsp0: got id=%0d res=%h fl=%b expected id=0 res=0 fl=0111", rsp_id, rsp_result, rsp_flags);
        end
        held_res = rsp_result; held_fl = rsp_flags;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== held_res || rsp_flags !== held_fl || rsp_id !== 1'b0) unstable++;
            if (req0_ready || req1_ready) ready_hi++;
        end
        n_cmp++;
        if (unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        n_cmp++;
        if (ready_hi != 0) begin n_err++; $display("FAIL bp_stall: got %0d ready cycles expected 0", ready_hi); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
            n_err++; $display("FAIL bp_pending_grant: got v/r0/r1=%b expected 001", {rsp_valid, req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_rsp(e);
        n_cmp++;
        if ({rsp_id, rsp_result, rsp_flags} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000}) begin
            n_err++; $display("FAIL bp_rsp1: got id=%0d res=%h fl=%b expected id=1 res=fffffffffffffffe fl=1000", rsp_id, rsp_result, rsp_flags);
        end
        consume();
    endtask

    task automatic test_overflow();
        bit ok;
        int e;
        accept(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, ok);
        wait_rsp(e);
        n_cmp++;
        if ({ok, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010}) begin
            n_err++;
            $display("FAIL overflow: got ok=%b id=%0d res=%h fl=%b expected ok=1 id=0 res=8000000000000000 fl=1010", ok, rsp_id, rsp_result, rsp_flags);
        end
        consume();
`ifdef ALU_SHARE_ARB_PERF_EN
        n_cmp++;
        if (grant_cnt0 !== 32'd6 || grant_cnt1 !== 32'd5) begin
            n_err++; $display("FAIL perf_counts: got %0d/%0d expected 6/5", grant_cnt0, grant_cnt1);
        end
`endif
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        int e, seen;
        accept(1'b0, 64'd9, 64'd9, 3'b010, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_cntrl, rsp_valid, rsp_id, rsp_result, rsp_flags} !== '0) begin
            n_err++;
            $display("FAIL midreset_clear: got a=%h b=%h c=%b v=%b id=%b res=%h fl=%b expected zeros",
                     alu_a, alu_b, alu_cntrl, rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
`ifdef ALU_SHARE_ARB_PERF_EN
        n_cmp++;
        if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin
            n_err++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL midreset_no_rsp: got %0d valid cycles expected 0", seen); end
        req0_a = 64'd2; req0_b = 64'd2; req0_op = 3'b010; req0_valid = 1'b1;
        req1_a = 64'd1; req1_b = 64'd1; req1_op = 3'b010; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL midreset_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(e);
        n_cmp++;
        if ({rsp_id, rsp_result} !== {1'b0, 64'd4}) begin
            n_err++; $display("FAIL midreset_rsp: got id=%0d res=%h expected id=0 res=4", rsp_id, rsp_result);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub();
        test_tie();
        test_backpressure();
        test_overflow();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
